// File: rtl/rx_msg_buffer.sv
// Double-buffered receive message store: acks RX RAM writes into a fill bank,
// commits or discards on end_msg, and serves committed messages oldest first.
// Optional build macro RX_BUF_STATS_EN enables the drop/error frame counters.
module rx_msg_buffer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              wr_req,
  output logic              wr_rdy,
  input  logic [15:0]       wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              hdr_valid,
  input  logic [7:0]        hdr_flag,
  input  logic [15:0]       hdr_len,
  input  logic              end_msg,
  input  logic              msg_ok,
  input  logic              msg_line,
  output logic              msg_avail,
  output logic [7:0]        msg_flag,
  output logic [15:0]       msg_len,
  output logic              msg_line_o,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              msg_release,
  output logic [7:0]        drop_cnt,
  output logic [7:0]        err_cnt,
  output logic [0:0]        wr_fsm_state
);

  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_WAIT = 1'b1;

  logic [0:0]  wr_state;
  logic [7:0]  bank_mem [0:1][0:(1<<ADDR_W)-1];
  logic [1:0]  full;
  logic        fill_bank;
  logic        rd_bank;
  logic        ovf;
  logic [7:0]  pend_flag;
  logic [15:0] pend_len;
  logic [7:0]  meta_flag [0:1];
  logic [15:0] meta_len  [0:1];
  logic        meta_line [0:1];

  logic        wr_accept;
  logic        wr_in_range;
  logic        wr_store;
  logic        rel_fire;
  logic [1:0]  full_rel;
  logic        commit;
  logic [1:0]  full_next;

  assign wr_fsm_state = wr_state;
  assign wr_accept    = (wr_state == WR_IDLE) && wr_req;
  assign wr_in_range  = {16'h0000, wr_addr} < DEPTH;
  assign wr_store     = wr_accept && wr_in_range && !full[fill_bank];

  // Invariant: whenever any bank is full, the read bank is the oldest full one.
  assign msg_avail  = full[rd_bank];
  assign msg_flag   = msg_avail ? meta_flag[rd_bank] : 8'h00;
  assign msg_len    = msg_avail ? meta_len[rd_bank]  : 16'h0000;
  assign msg_line_o = msg_avail ? meta_line[rd_bank] : 1'b0;

  // Release is applied before the commit decision so a commit can reuse the freed bank.
  always_comb begin
    rel_fire  = msg_release && msg_avail;
    full_rel  = full;
    if (rel_fire) full_rel[rd_bank] = 1'b0;
    commit    = end_msg && msg_ok && !ovf && !full_rel[fill_bank];
    full_next = full_rel;
    if (commit) full_next[fill_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_state <= WR_IDLE;
      wr_rdy   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          wr_rdy <= wr_req;
          if (wr_req) wr_state <= WR_WAIT;
        end
        default: begin
          wr_rdy <= 1'b0;
          if (!wr_req) wr_state <= WR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_store) bank_mem[fill_bank][wr_addr[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= msg_avail ? bank_mem[rd_bank][rd_addr] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      ovf       <= 1'b0;
      pend_flag <= 8'h00;
      pend_len  <= 16'h0000;
    end else begin
      if (hdr_valid) begin
        pend_flag <= hdr_flag;
        pend_len  <= hdr_len;
        ovf       <= {16'h0000, hdr_len} > DEPTH;
      end
      if (wr_accept && !wr_in_range) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      full         <= 2'b00;
      fill_bank    <= 1'b0;
      rd_bank      <= 1'b0;
      meta_flag[0] <= 8'h00;
      meta_flag[1] <= 8'h00;
      meta_len[0]  <= 16'h0000;
      meta_len[1]  <= 16'h0000;
      meta_line[0] <= 1'b0;
      meta_line[1] <= 1'b0;
    end else begin
      full <= full_next;
      if (rel_fire) rd_bank <= ~rd_bank;
      if (commit) begin
        meta_flag[fill_bank] <= pend_flag;
        meta_len[fill_bank]  <= pend_len;
        meta_line[fill_bank] <= msg_line;
        fill_bank            <= ~fill_bank;
      end
    end
  end

`ifdef RX_BUF_STATS_EN
  logic drop_evt;
  logic err_evt;

  assign err_evt  = end_msg && !msg_ok;
  assign drop_evt = end_msg && msg_ok && !commit;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      drop_cnt <= 8'h00;
      err_cnt  <= 8'h00;
    end else begin
      if (drop_evt && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
      if (err_evt && err_cnt != 8'hFF)   err_cnt  <= err_cnt + 8'h01;
    end
  end
`else
  assign drop_cnt = 8'h00;
  assign err_cnt  = 8'h00;
`endif

endmodule

// File: tb/tb_rx_msg_buffer.sv
// Directed testbench for rx_msg_buffer: framing, write handshake, commit/drop,
// bank ordering, simultaneous events and asynchronous reset.
module tb_rx_msg_buffer;

  localparam int ADDR_W = 10;
`ifdef RX_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              wr_req = 1'b0;
  logic              wr_rdy;
  logic [15:0]       wr_addr = 16'h0;
  logic [7:0]        wr_data = 8'h0;
  logic              hdr_valid = 1'b0;
  logic [7:0]        hdr_flag = 8'h0;
  logic [15:0]       hdr_len = 16'h0;
  logic              end_msg = 1'b0;
  logic              msg_ok = 1'b0;
  logic              msg_line = 1'b0;
  logic              msg_avail;
  logic [7:0]        msg_flag;
  logic [15:0]       msg_len;
  logic              msg_line_o;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              msg_release = 1'b0;
  logic [7:0]        drop_cnt;
  logic [7:0]        err_cnt;
  logic [0:0]        wr_fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  rx_msg_buffer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_l(rst_l), .wr_req(wr_req), .wr_rdy(wr_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data), .hdr_valid(hdr_valid),
    .hdr_flag(hdr_flag), .hdr_len(hdr_len), .end_msg(end_msg),
    .msg_ok(msg_ok), .msg_line(msg_line), .msg_avail(msg_avail),
    .msg_flag(msg_flag), .msg_len(msg_len), .msg_line_o(msg_line_o),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .msg_release(msg_release), .drop_cnt(drop_cnt), .err_cnt(err_cnt),
    .wr_fsm_state(wr_fsm_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                          output logic r1, output logic r2);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    tick(); r1 = wr_rdy;
    wr_req = 1'b0;
    tick(); r2 = wr_rdy;
  endtask

  task automatic send_hdr(input logic [7:0] f, input logic [15:0] l);
    hdr_valid = 1'b1; hdr_flag = f; hdr_len = l;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic send_end(input logic ok, input logic line);
    end_msg = 1'b1; msg_ok = ok; msg_line = line;
    tick();
    end_msg = 1'b0; msg_ok = 1'b0; msg_line = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_release();
    msg_release = 1'b1;
    tick();
    msg_release = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f, input logic [15:0] l, input logic [7:0] d0,
                            input int n, input logic ok, input logic line);
    logic r1, r2;
    send_hdr(f, l);
    for (int i = 0; i < n; i++) do_write(16'(i), d0 + 8'(i), r1, r2);
    send_end(ok, line);
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) tick();
    if (wr_rdy !== 1'b0) begin $display("FAIL reset_wr_rdy got=%h exp=0", wr_rdy); n_err++; end n_cmp++;
    if (msg_avail !== 1'b0) begin $display("FAIL reset_avail got=%h exp=0", msg_avail); n_err++; end n_cmp++;
    if (msg_flag !== 8'h00) begin $display("FAIL reset_flag got=%h exp=00", msg_flag); n_err++; end n_cmp++;
    if (msg_len !== 16'h0) begin $display("FAIL reset_len got=%h exp=0000", msg_len); n_err++; end n_cmp++;
    if (rd_data !== 8'h00) begin $display("FAIL reset_rd_data got=%h exp=00", rd_data); n_err++; end n_cmp++;
    if (drop_cnt !== 8'h00 || err_cnt !== 8'h00) begin $display("FAIL reset_cnt got=%h/%h exp=00/00", drop_cnt, err_cnt); n_err++; end n_cmp++;
    if (wr_fsm_state !== 1'b0) begin $display("FAIL reset_fsm got=%h exp=0", wr_fsm_state); n_err++; end n_cmp++;
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic r1, r2;
    logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    send_hdr(8'h11, 16'd4);
    for (int i = 0; i < 4; i++) begin
      do_write(16'(i), exp_d[i], r1, r2);
      if (r1 !== 1'b1 || r2 !== 1'b0) begin $display("FAIL basic_wr_rdy[%0d] got=%b%b exp=10", i, r1, r2); n_err++; end n_cmp++;
    end
    if (msg_avail !== 1'b0) begin $display("FAIL basic_avail_pre got=%h exp=0", msg_avail); n_err++; end n_cmp++;
    send_end(1'b1, 1'b1);
    if (msg_avail !== 1'b1) begin $display("FAIL basic_avail got=%h exp=1", msg_avail); n_err++; end n_cmp++;
    if (msg_flag !== 8'h11) begin $display("FAIL basic_flag got=%h exp=11", msg_flag); n_err++; end n_cmp++;
    if (msg_len !== 16'd4) begin $display("FAIL basic_len got=%h exp=0004", msg_len); n_err++; end n_cmp++;
    if (msg_line_o !== 1'b1) begin $display("FAIL basic_line got=%h exp=1", msg_line_o); n_err++; end n_cmp++;
    for (int i = 0; i < 4; i++) begin
      do_read(ADDR_W'(i));
      if (rd_data !== exp_d[i]) begin $display("FAIL basic_read[%0d] got=%h exp=%h", i, rd_data, exp_d[i]); n_err++; end n_cmp++;
    end
    do_release();
    if (msg_avail !== 1'b0) begin $display("FAIL basic_release got=%h exp=0", msg_avail); n_err++; end n_cmp++;
  endtask

  task automatic test_held_request();
    int pulses = 0;
    send_hdr(8'h22, 16'd1);
    wr_req = 1'b1; wr_addr = 16'h0; wr_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wr_rdy === 1'b1) pulses++;
      wr_data = 8'h77;
    end
    wr_req = 1'b0;
    tick();
    if (wr_rdy === 1'b1) pulses++;
    if (pulses !== 1) begin $display("FAIL held_pulses got=%0d exp=1", pulses); n_err++; end n_cmp++;
    send_end(1'b1, 1'b0);
    do_read('0);
    if (rd_data !== 8'h55) begin $display("FAIL held_data got=%h exp=55", rd_data); n_err++; end n_cmp++;
    if (msg_line_o !== 1'b0) begin $display("FAIL held_line got=%h exp=0", msg_line_o); n_err++; end n_cmp++;
    do_release();
  endtask

  task automatic test_bad_frame();
    send_frame(8'h33, 16'd2, 8'hB0, 2, 1'b0, 1'b0);
    if (msg_avail !== 1'b0) begin $display("FAIL bad_avail got=%h exp=0", msg_avail); n_err++; end n_cmp++;
    if (err_cnt !== (STATS ? 8'd1 : 8'd0)) begin $display("FAIL bad_err_cnt got=%h exp=%h", err_cnt, STATS ? 8'd1 : 8'd0); n_err++; end n_cmp++;
    if (drop_cnt !== 8'd0) begin $display("FAIL bad_drop_cnt got=%h exp=00", drop_cnt); n_err++; end n_cmp++;
  endtask

  task automatic test_bank_full_drop();
    send_frame(8'h41, 16'd2, 8'h10, 2, 1'b1, 1'b0);
    send_frame(8'h42, 16'd3, 8'h20, 3, 1'b1, 1'b1);
    send_frame(8'h43, 16'd1, 8'h30, 1, 1'b1, 1'b0);
    if (drop_cnt !== (STATS ? 8'd1 : 8'd0)) begin $display("FAIL full_drop_cnt got=%h exp=%h", drop_cnt, STATS ? 8'd1 : 8'd0); n_err++; end n_cmp++;
    if (msg_flag !== 8'h41 || msg_len !== 16'd2) begin $display("FAIL full_first_meta got=%h/%h exp=41/0002", msg_flag, msg_len); n_err++; end n_cmp++;
    for (int i = 0; i < 2; i++) begin
      do_read(ADDR_W'(i));
      if (rd_data !== 8'h10 + 8'(i)) begin $display("FAIL full_first_read[%0d] got=%h exp=%h", i, rd_data, 8'h10 + 8'(i)); n_err++; end n_cmp++;
    end
    do_release();
    if (msg_flag !== 8'h42 || msg_len !== 16'd3 || msg_line_o !== 1'b1) begin $display("FAIL full_second_meta got=%h/%h/%h exp=42/0003/1", msg_flag, msg_len, msg_line_o); n_err++; end n_cmp++;
    for (int i = 0; i < 3; i++) begin
      do_read(ADDR_W'(i));
      if (rd_data !== 8'h20 + 8'(i)) begin $display("FAIL full_second_read[%0d] got=%h exp=%h", i, rd_data, 8'h20 + 8'(i)); n_err++; end n_cmp++;
    end
    do_release();
    if (msg_avail !== 1'b0) begin $display("FAIL full_empty got=%h exp=0", msg_avail); n_err++; end n_cmp++;
  endtask

  task automatic test_addr_range();
    logic r1, r2;
    send_hdr(8'h50, 16'd2);
    do_write(16'h0000, 8'h01, r1, r2);
    do_write(16'h0400, 8'h02, r1, r2);
    if (r1 !== 1'b1 || r2 !== 1'b0) begin $display("FAIL range_ack got=%b%b exp=10", r1, r2); n_err++; end n_cmp++;
    send_end(1'b1, 1'b0);
    if (msg_avail !== 1'b0) begin $display("FAIL range_avail got=%h exp=0", msg_avail); n_err++; end n_cmp++;
    if (drop_cnt !== (STATS ? 8'd2 : 8'd0)) begin $display("FAIL range_drop_cnt got=%h exp=%h", drop_cnt, STATS ? 8'd2 : 8'd0); n_err++; end n_cmp++;
    send_frame(8'h51, 16'd1025, 8'h03, 1, 1'b1, 1'b0);
    if (msg_avail !== 1'b0) begin $display("FAIL hdrlen_avail got=%h exp=0", msg_avail); n_err++; end n_cmp++;
    if (drop_cnt !== (STATS ? 8'd3 : 8'd0)) begin $display("FAIL hdrlen_drop_cnt got=%h exp=%h", drop_cnt, STATS ? 8'd3 : 8'd0); n_err++; end n_cmp++;
    send_frame(8'h52, 16'd1024, 8'hCC, 1, 1'b1, 1'b0);
    if (msg_avail !== 1'b1 || msg_len !== 16'd1024) begin $display("FAIL ovf_clear got=%h/%h exp=1/0400", msg_avail, msg_len); n_err++; end n_cmp++;
    do_read('0);
    if (rd_data !== 8'hCC) begin $display("FAIL ovf_clear_read got=%h exp=cc", rd_data); n_err++; end n_cmp++;
    do_release();
    do_read('0);
    if (rd_data !== 8'h00) begin $display("FAIL empty_read got=%h exp=00", rd_data); n_err++; end n_cmp++;
  endtask

  task automatic test_simultaneous();
    logic r1, r2;
    send_frame(8'h60, 16'd1, 8'h61, 1, 1'b1, 1'b0);
    send_frame(8'h70, 16'd1, 8'h71, 1, 1'b1, 1'b0);
    // Fill bank is full here, so this byte is acked but never stored.
    send_hdr(8'h80, 16'd1);
    do_write(16'h0000, 8'h81, r1, r2);
    msg_release = 1'b1; end_msg = 1'b1; msg_ok = 1'b1; msg_line = 1'b1;
    tick();
    msg_release = 1'b0; end_msg = 1'b0; msg_ok = 1'b0; msg_line = 1'b0;
    if (msg_avail !== 1'b1 || msg_flag !== 8'h70) begin $display("FAIL simul_avail got=%h/%h exp=1/70", msg_avail, msg_flag); n_err++; end n_cmp++;
    if (drop_cnt !== (STATS ? 8'd3 : 8'd0)) begin $display("FAIL simul_drop_cnt got=%h exp=%h", drop_cnt, STATS ? 8'd3 : 8'd0); n_err++; end n_cmp++;
    do_release();
    if (msg_flag !== 8'h80 || msg_line_o !== 1'b1) begin $display("FAIL simul_new_meta got=%h/%h exp=80/1", msg_flag, msg_line_o); n_err++; end n_cmp++;
    do_read('0);
    if (rd_data !== 8'h61) begin $display("FAIL simul_unstored got=%h exp=61", rd_data); n_err++; end n_cmp++;
    do_release();
    send_hdr(8'h90, 16'd1);
    do_write(16'h0000, 8'h91, r1, r2);
    end_msg = 1'b1; msg_ok = 1'b1; hdr_valid = 1'b1; hdr_flag = 8'h95; hdr_len = 16'd3;
    tick();
    end_msg = 1'b0; msg_ok = 1'b0; hdr_valid = 1'b0;
    if (msg_flag !== 8'h90 || msg_len !== 16'd1) begin $display("FAIL hdr_end_old got=%h/%h exp=90/0001", msg_flag, msg_len); n_err++; end n_cmp++;
    send_end(1'b1, 1'b0);
    do_release();
    if (msg_flag !== 8'h95 || msg_len !== 16'd3) begin $display("FAIL hdr_end_new got=%h/%h exp=95/0003", msg_flag, msg_len); n_err++; end n_cmp++;
    do_release();
  endtask

  task automatic test_reset_mid_write();
    send_frame(8'hB1, 16'd1, 8'hB2, 1, 1'b1, 1'b1);
    do_read('0);
    send_hdr(8'hC0, 16'd2);
    wr_req = 1'b1; wr_addr = 16'h0; wr_data = 8'hC1;
    tick();
    rst_l = 1'b0;
    #1;
    if (wr_rdy !== 1'b0 || wr_fsm_state !== 1'b0) begin $display("FAIL mid_reset_wr got=%h/%h exp=0/0", wr_rdy, wr_fsm_state); n_err++; end n_cmp++;
    if (msg_avail !== 1'b0 || msg_flag !== 8'h00 || msg_len !== 16'h0 || msg_line_o !== 1'b0) begin
      $display("FAIL mid_reset_msg got=%h/%h/%h/%h exp=0/00/0000/0", msg_avail, msg_flag, msg_len, msg_line_o); n_err++;
    end n_cmp++;
    if (rd_data !== 8'h00 || drop_cnt !== 8'h00 || err_cnt !== 8'h00) begin
      $display("FAIL mid_reset_data got=%h/%h/%h exp=00/00/00", rd_data, drop_cnt, err_cnt); n_err++;
    end n_cmp++;
    wr_req = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_request();
    test_bad_frame();
    test_bank_full_drop();
    test_addr_range();
    test_simultaneous();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
